// File: rtl/conv_pkg.sv
// Shared types and requantization helpers for the convolution output path.
package conv_pkg;

  typedef enum logic [1:0] {
    s_obuf_reset,
    s_obuf_fill,
    s_obuf_full,
    s_obuf_drain
  } t_conv_obuf_state;

  // Two's-complement saturation bounds for an ow-bit output word.
  function automatic int sat_hi(input int ow);
    return (1 <<< (ow - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int ow);
    return -(1 <<< (ow - 1));
  endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantizer: optional ReLU (CONV_OBUF_RELU_EN), arithmetic shift, saturation.
module conv_requant
  import conv_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] q_o
);

  localparam logic signed [31:0] HI_W = 32'(sat_hi(OUT_W));
  localparam logic signed [31:0] LO_W = 32'(sat_lo(OUT_W));

  logic signed [ACC_W-1:0] relu_v;
  logic signed [ACC_W-1:0] sh_v;
  logic signed [31:0]      wide_v;

  always_comb begin
    relu_v = signed'(acc_i);
`ifdef CONV_OBUF_RELU_EN
    if (acc_i[ACC_W-1]) relu_v = '0;
`endif
    sh_v   = relu_v >>> SHIFT;
    wide_v = {{(32-ACC_W){sh_v[ACC_W-1]}}, sh_v};
    if (wide_v > HI_W)      q_o = HI_W[OUT_W-1:0];
    else if (wide_v < LO_W) q_o = LO_W[OUT_W-1:0];
    else                    q_o = wide_v[OUT_W-1:0];
  end

endmodule

// File: rtl/conv_obuf.sv
// Output buffer: fills a requantized vector from the conv unit, then drains it over valid/ready.
// Optional ReLU is enabled by defining CONV_OBUF_RELU_EN.
module conv_obuf
  import conv_pkg::*;
#(
  parameter int output_size          = 512,
  parameter int acc_width            = 16,
  parameter int output_datatype_size = 8,
  parameter int shift                = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_we,
  input  logic [acc_width-1:0]            i_data,
  input  logic                            i_start,
  output logic                            o_busy,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [output_datatype_size-1:0] o_data,
  output logic [$clog2(output_size)-1:0]  o_addr,
  output logic                            o_overflow
);

  localparam int AW = $clog2(output_size);
  localparam logic [AW-1:0] LAST = AW'(output_size - 1);

  t_conv_obuf_state state_q, state_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [output_datatype_size-1:0] data_q;
  logic [output_datatype_size-1:0] rq_word;
  logic          wr_en;
  logic          accept;

  logic [output_datatype_size-1:0] mem_q [output_size];

  conv_requant #(
    .ACC_W(acc_width),
    .OUT_W(output_datatype_size),
    .SHIFT(shift)
  ) u_requant (
    .acc_i(i_data),
    .q_o  (rq_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= s_obuf_reset;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_obuf_reset: if (i_we) state_d = (LAST == '0) ? s_obuf_full : s_obuf_fill;
      s_obuf_fill:  if (i_we && count_q == LAST) state_d = s_obuf_full;
      s_obuf_full:  if (i_start) state_d = s_obuf_drain;
      s_obuf_drain: if (accept && addr_q == LAST) state_d = s_obuf_reset;
      default:      state_d = s_obuf_reset;
    endcase
  end

  always_comb begin
    accept  = valid_q & i_ready;
    wr_en   = i_we && (state_q == s_obuf_reset || state_q == s_obuf_fill);
    count_d = count_q;
    if (state_d == s_obuf_reset) count_d = '0;
    else if (wr_en)              count_d = count_q + AW'(1);
    // The read pointer doubles as o_addr; it wraps to 0 after the last beat.
    addr_d = addr_q;
    if (state_q == s_obuf_full && i_start) addr_d = '0;
    else if (state_q == s_obuf_drain && accept) addr_d = addr_q + AW'(1);
    valid_d = (state_d == s_obuf_drain);
    busy_d  = (state_d == s_obuf_full) || (state_d == s_obuf_drain);
    ovf_d   = ovf_q | (i_we && (state_q == s_obuf_full || state_q == s_obuf_drain));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      data_q  <= mem_q[addr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q] <= rq_word;
  end

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_addr     = addr_q;
  assign o_overflow = ovf_q;

endmodule
